// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input framer: default sizes, FSM state
// encoding and the address bit-reversal helper used for replay ordering.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FFT_POINTS_DEF = 1024;
  localparam int ADDR_W_DEF     = $clog2(FFT_POINTS_DEF);
  // Widest address the bit-reversal helper handles (64K-point frames).
  localparam int ADDR_W_MAX     = 16;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // Reverse the low 'width' bits of addr; upper result bits are zero.
  // Built as a shift register so no variable bit index is needed.
  function automatic logic [ADDR_W_MAX-1:0] bit_rev(input logic [ADDR_W_MAX-1:0] addr,
                                                    input int width);
    logic [ADDR_W_MAX-1:0] a;
    logic [ADDR_W_MAX-1:0] r;
    a = addr;
    r = '0;
    for (int i = 0; i < ADDR_W_MAX; i++) begin
      if (i < width) begin
        r = {r[ADDR_W_MAX-2:0], a[0]};
        a = a >> 1;
      end else begin
        r = r;
        a = a;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Frame buffer: simple dual-port RAM, one write port and one registered
// read port. The array carries no reset; contents are always written
// before they are read back.
module fft_frame_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port: store an accepted sample.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: registered read, holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_input_framer_chk.sv
// Runtime invariants of the framer FSM and its output handshake.
module fft_input_framer_chk
  import fft_pkg::*;
(
  input logic   clk,
  input logic   rst_i,
  input state_e state_i,
  input logic   in_ready_i,
  input logic   fft_start_i
);

  // The source may only be offered space while a frame is being filled.
  a_ready_only_in_fill: assert property (@(posedge clk)
    rst_i || (in_ready_i == (state_i == ST_FILL)));

  // Frame samples reach the FFT core only inside the replay window.
  a_start_only_in_drain: assert property (@(posedge clk)
    rst_i || !fft_start_i || (state_i == ST_DRAIN));

endmodule

// File: rtl/fft_input_framer.sv
// FFT input framer: gathers FFT_POINTS samples into a frame buffer, replays
// them to the FFT core (bit-reversed or natural order) with fft_start held
// for the whole frame, then waits for fft_done before refilling.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FFT_POINTS  = FFT_POINTS_DEF,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fft_start,
  output logic [DATA_WIDTH-1:0] fft_data,
  input  logic                  fft_done,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int ADDR_W = $clog2(FFT_POINTS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FFT_POINTS - 1);
  // rd_ptr carries one extra bit so it can count past the last address.
  localparam logic [ADDR_W:0]   POINTS_EXT = (ADDR_W + 1)'(FFT_POINTS);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  fft_start_q, fft_start_d;
  logic [DATA_WIDTH-1:0] fft_data_q, fft_data_d;
  logic                  in_ready_q, in_ready_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  accept_s;
  logic                  drop_s;
  logic [ADDR_W_MAX-1:0] rev_full_s;
  logic [ADDR_W-1:0]     rd_addr_s;
  logic [DATA_WIDTH-1:0] ram_rd_data_s;

  assign accept_s = in_valid && in_ready_q;
  assign drop_s   = in_valid && !in_ready_q;

  // Replay address: bit-reversed or natural view of the read pointer.
  always_comb begin
    rev_full_s = bit_rev(ADDR_W_MAX'(rd_ptr_q[ADDR_W-1:0]), ADDR_W);
    if (BIT_REVERSE != 0) begin
      rd_addr_s = ADDR_W'(rev_full_s);
    end else begin
      rd_addr_s = rd_ptr_q[ADDR_W-1:0];
    end
  end

  // Next-state logic for the FSM, pointers, counters and output registers.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_DRAIN: begin
        if (rd_ptr_q < POINTS_EXT) begin
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + (ADDR_W + 1)'(1);
        end else begin
          rd_valid_d = 1'b0;
        end
        // Last replayed word is on the output: fft_start falls on this edge.
        if (fft_start_q && !rd_valid_q) begin
          state_d     = ST_WAIT_DONE;
          rd_ptr_d    = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_WAIT_DONE: begin
        if (fft_done) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    in_ready_d  = (state_d == ST_FILL);
    fft_start_d = rd_valid_q;
    if (rd_valid_q) begin
      fft_data_d = ram_rd_data_s;
    end else begin
      fft_data_d = fft_data_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      fft_start_q <= 1'b0;
      fft_data_q  <= '0;
      in_ready_q  <= 1'b1;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      fft_start_q <= fft_start_d;
      fft_data_q  <= fft_data_d;
      in_ready_q  <= in_ready_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fft_frame_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FFT_POINTS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .wr_en_i  (accept_s),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(in_data),
    .rd_en_i  (rd_valid_d),
    .rd_addr_i(rd_addr_s),
    .rd_data_o(ram_rd_data_s)
  );

  fft_input_framer_chk u_chk (
    .clk        (clk),
    .rst_i      (rst),
    .state_i    (state_q),
    .in_ready_i (in_ready_q),
    .fft_start_i(fft_start_q)
  );

  assign in_ready  = in_ready_q;
  assign fft_start = fft_start_q;
  assign fft_data  = fft_data_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
